// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single synchronous memory port.
// Round-robin between a processor (master 0) and a DMA/debug loader (master 1),
// with optional locked bursts capped at MAX_BURST beats. The winning command is
// registered onto the memory port; read data returns two cycles after the grant.
module mem_port_arbiter #(
    parameter int unsigned AW        = 16,
    parameter int unsigned DW        = 16,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          m0_req_i,
    input  logic          m0_lock_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    output logic          m0_gnt_o,
    output logic          m0_rvalid_o,
    output logic [DW-1:0] m0_rdata_o,

    input  logic          m1_req_i,
    input  logic          m1_lock_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m1_gnt_o,
    output logic          m1_rvalid_o,
    output logic [DW-1:0] m1_rdata_o,

    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          mem_we_o,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BurstMax = CW'(MAX_BURST);
    // A burst cap of one beat means locking can never hold the port.
    localparam bit MultiBeat = (MAX_BURST > 1);

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1
    } state_e;

    state_e        state_q, state_d;
    logic          rr_q, rr_d;        // 1 = master 1 favoured on a tie
    logic [CW-1:0] cnt_q, cnt_d;      // beats granted in current ownership

    logic          gnt0, gnt1, gnt_any;
    logic          win_lock, win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          mem_we_q;

    // Read-return pipeline: stage 1 aligns with the memory command, stage 2 with the data.
    logic          rd1_vld_q, rd1_own_q;
    logic          rd2_vld_q, rd2_own_q;

    // Winner's command mux; only meaningful when a grant is given.
    always_comb begin
        gnt_any   = gnt0 | gnt1;
        win_lock  = gnt1 ? m1_lock_i  : m0_lock_i;
        win_we    = gnt1 ? m1_we_i    : m0_we_i;
        win_addr  = gnt1 ? m1_addr_i  : m0_addr_i;
        win_wdata = gnt1 ? m1_wdata_i : m0_wdata_i;
    end

    // Grant decode and arbitration next-state.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;

        unique case (state_q)
            StIdle: begin
                gnt0 = m0_req_i & (~m1_req_i | ~rr_q);
                gnt1 = m1_req_i & (~m0_req_i |  rr_q);
            end
            StOwn0:  gnt0 = m0_req_i;
            StOwn1:  gnt1 = m1_req_i;
            default: ;
        endcase

        if (rst_i) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (gnt_any) begin
                    // Priority passes to the master that did not win.
                    rr_d = gnt0;
                    if (win_lock && MultiBeat) begin
                        state_d = gnt1 ? StOwn1 : StOwn0;
                        cnt_d   = CW'(1);
                    end
                end
            end
            StOwn0, StOwn1: begin
                if (gnt_any) begin
                    if (!win_lock || (cnt_q + CW'(1)) == BurstMax) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        rr_d    = gnt0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    // Owner withdrew its request: release immediately.
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Register the winning beat onto the memory port and track outstanding reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rd1_vld_q   <= 1'b0;
            rd1_own_q   <= 1'b0;
            rd2_vld_q   <= 1'b0;
            rd2_own_q   <= 1'b0;
        end else begin
            if (gnt_any) begin
                mem_addr_q  <= win_addr;
                mem_wdata_q <= win_wdata;
                mem_we_q    <= win_we;
            end else begin
                mem_we_q    <= 1'b0;
            end
            rd1_vld_q <= gnt_any & ~win_we;
            rd1_own_q <= gnt1;
            rd2_vld_q <= rd1_vld_q;
            rd2_own_q <= rd1_own_q;
        end
    end

    // Outputs: grants are combinational, read data is a passthrough steered by the pipeline.
    always_comb begin
        m0_gnt_o    = gnt0;
        m1_gnt_o    = gnt1;
        m0_rvalid_o = rd2_vld_q & ~rd2_own_q;
        m1_rvalid_o = rd2_vld_q &  rd2_own_q;
        m0_rdata_o  = mem_rdata_i;
        m1_rdata_o  = mem_rdata_i;
        mem_addr_o  = mem_addr_q;
        mem_wdata_o = mem_wdata_q;
        mem_we_o    = mem_we_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: per-cycle model comparison plus
// directed scenarios with literal expectations.
module tb_mem_port_arbiter;

    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        m0_req = 0, m0_lock = 0, m0_we = 0;
    logic [15:0] m0_addr = 0, m0_wdata = 0;
    logic        m1_req = 0, m1_lock = 0, m1_we = 0;
    logic [15:0] m1_addr = 0, m1_wdata = 0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
    logic [15:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
    logic [15:0] mem_rdata;

    mem_port_arbiter #(.AW(16), .DW(16), .MAX_BURST(MAX_BURST)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_lock_i(m0_lock), .m0_we_i(m0_we),
        .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_lock_i(m1_lock), .m1_we_i(m1_we),
        .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
        .mem_rdata_i(mem_rdata)
    );

    // Synchronous memory, 1-cycle read latency, preloaded with A000+index.
    logic [15:0] mem [256];
    bit          mem_init = 0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 + 16'(i);
            mem_init <= 1;
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[7:0]];
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Master drivers: each presents the head of its queue until granted.
    typedef struct packed {
        logic        we;
        logic        lock;
        logic [15:0] addr;
        logic [15:0] wdata;
    } beat_t;
    beat_t q0[$];
    beat_t q1[$];
    bit    g0_s = 0, g1_s = 0;

    always @(posedge clk) begin
        #1;
        if (g0_s && q0.size() > 0) void'(q0.pop_front());
        if (g1_s && q1.size() > 0) void'(q1.pop_front());
        if (q0.size() > 0) begin
            m0_req = 1; m0_we = q0[0].we; m0_lock = q0[0].lock;
            m0_addr = q0[0].addr; m0_wdata = q0[0].wdata;
        end else begin
            m0_req = 0; m0_lock = 0;
        end
        if (q1.size() > 0) begin
            m1_req = 1; m1_we = q1[0].we; m1_lock = q1[0].lock;
            m1_addr = q1[0].addr; m1_wdata = q1[0].wdata;
        end else begin
            m1_req = 0; m1_lock = 0;
        end
    end

    // Event logs of observed DUT behaviour for the directed literal checks.
    typedef struct {
        int          cyc;
        int          m;
        logic [15:0] d;
    } ev_t;
    ev_t         glog[$];
    ev_t         rlog[$];
    logic [15:0] alog[$];

    // Reference model: ownership, tie priority, beat count, expected port and returns.
    logic [15:0] ref_mem [256];
    bit          ref_init = 0;
    int          own = -1, rr = 0, cnt = 0;
    logic        exp_we = 0;
    logic [15:0] exp_addr = 0, exp_wdata = 0;
    bit          p1_v = 0, p2_v = 0;
    int          p1_m = 0, p2_m = 0;
    logic [15:0] p1_d = 0, p2_d = 0;
    bit          eg0, eg1;

    always @(negedge clk) begin
        int          w, beats;
        logic        bwe, block;
        logic [15:0] baddr, bwd;
        if (!ref_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = 16'hA000 + 16'(i);
            ref_init = 1;
        end
        cyc++;
        eg0 = 0; eg1 = 0;
        if (!rst) begin
            if (own < 0) begin
                eg0 = m0_req && (!m1_req || rr == 0);
                eg1 = m1_req && (!m0_req || rr == 1);
            end else if (own == 0) begin
                eg0 = m0_req;
            end else begin
                eg1 = m1_req;
            end
        end
        chk("gnt0", m0_gnt, eg0);
        chk("gnt1", m1_gnt, eg1);
        chk("mem_we", mem_we, exp_we);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, exp_wdata);
        chk("rvalid0", m0_rvalid, p2_v && p2_m == 0);
        chk("rvalid1", m1_rvalid, p2_v && p2_m == 1);
        if (p2_v) chk("rdata", (p2_m == 1) ? m1_rdata : m0_rdata, p2_d);

        if (g0_s || g1_s) alog.push_back(mem_addr);
        if (m0_gnt) glog.push_back('{cyc, 0, 16'h0});
        if (m1_gnt) glog.push_back('{cyc, 1, 16'h0});
        if (m0_rvalid) rlog.push_back('{cyc, 0, m0_rdata});
        if (m1_rvalid) rlog.push_back('{cyc, 1, m1_rdata});
        g0_s = m0_gnt;
        g1_s = m1_gnt;

        if (rst) begin
            own = -1; rr = 0; cnt = 0;
            exp_we = 0; exp_addr = 0; exp_wdata = 0;
            p1_v = 0; p2_v = 0;
        end else begin
            p2_v = p1_v; p2_m = p1_m; p2_d = p1_d;
            p1_v = 0;
            if (eg0 || eg1) begin
                w     = eg1 ? 1 : 0;
                bwe   = w ? m1_we : m0_we;
                block = w ? m1_lock : m0_lock;
                baddr = w ? m1_addr : m0_addr;
                bwd   = w ? m1_wdata : m0_wdata;
                exp_we = bwe; exp_addr = baddr; exp_wdata = bwd;
                if (bwe) ref_mem[baddr[7:0]] = bwd;
                else begin
                    p1_v = 1; p1_m = w; p1_d = ref_mem[baddr[7:0]];
                end
                beats = (own < 0) ? 1 : cnt + 1;
                rr = 1 - w;
                if (block && beats < MAX_BURST) begin
                    own = w; cnt = beats;
                end else begin
                    own = -1; cnt = 0;
                end
            end else begin
                exp_we = 0; own = -1; cnt = 0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain_in_time", n < 200, 1);
        repeat (4) @(posedge clk);
    endtask

    task automatic clear_logs();
        glog.delete(); rlog.delete(); alog.delete();
    endtask

    initial begin
        int          n;
        int          c0;
        logic [15:0] exp_d;
        // T1: reset held, m0 requesting.
        q0.push_back('{1'b0, 1'b0, 16'h0001, 16'h0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t1_rst_gnt0", m0_gnt, 0);
            chk("t1_rst_we", mem_we, 0);
            chk("t1_rst_rv", m0_rvalid | m1_rvalid, 0);
        end
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("t1_first_gnt", m0_gnt, 1);
        wait_idle();

        // T2: single m0 read.
        clear_logs();
        @(negedge clk);
        q0.push_back('{1'b0, 1'b0, 16'h0010, 16'h0});
        wait_idle();
        chk("t2_ngnt", glog.size(), 1);
        chk("t2_nrv", rlog.size(), 1);
        chk("t2_naddr", alog.size(), 1);
        if (glog.size() == 1 && rlog.size() == 1 && alog.size() == 1) begin
            chk("t2_addr", alog[0], 16'h0010);
            chk("t2_lat", rlog[0].cyc - glog[0].cyc, 2);
            chk("t2_rv_m", rlog[0].m, 0);
            chk("t2_data", rlog[0].d, 16'hA010);
        end

        // T3: both masters stream reads; m0 won last, so m1 leads.
        clear_logs();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            q0.push_back('{1'b0, 1'b0, 16'h0030 + 16'(k), 16'h0});
            q1.push_back('{1'b0, 1'b0, 16'h0040 + 16'(k), 16'h0});
        end
        wait_idle();
        chk("t3_ngnt", glog.size(), 8);
        chk("t3_nrv", rlog.size(), 8);
        if (glog.size() == 8 && rlog.size() == 8) begin
            c0 = glog[0].cyc;
            for (int k = 0; k < 8; k++) begin
                chk("t3_gnt_m", glog[k].m, (k % 2 == 0) ? 1 : 0);
                chk("t3_gnt_cyc", glog[k].cyc, c0 + k);
                chk("t3_rv_m", rlog[k].m, (k % 2 == 0) ? 1 : 0);
                chk("t3_rv_cyc", rlog[k].cyc, c0 + k + 2);
                exp_d = ((k % 2 == 0) ? 16'hA040 : 16'hA030) + 16'(k / 2);
                chk("t3_rv_data", rlog[k].d, exp_d);
            end
        end

        // T4: m1 locked 6-beat write burst against a pending m0 read.
        clear_logs();
        @(negedge clk);
        for (int k = 0; k < 6; k++)
            q1.push_back('{1'b1, 1'b1, 16'h0020 + 16'(k), 16'h5500 + 16'(k)});
        q0.push_back('{1'b0, 1'b0, 16'h0050, 16'h0});
        wait_idle();
        chk("t4_ngnt", glog.size(), 7);
        chk("t4_nrv", rlog.size(), 1);
        if (glog.size() == 7 && rlog.size() == 1) begin
            c0 = glog[0].cyc;
            for (int k = 0; k < 7; k++) begin
                chk("t4_gnt_m", glog[k].m, (k == 4) ? 0 : 1);
                chk("t4_gnt_cyc", glog[k].cyc, c0 + k);
            end
            chk("t4_rv_cyc", rlog[0].cyc, c0 + 6);
            chk("t4_rv_data", rlog[0].d, 16'hA050);
        end
        clear_logs();
        @(negedge clk);
        q0.push_back('{1'b0, 1'b0, 16'h0023, 16'h0});
        wait_idle();
        chk("t4_readback_n", rlog.size(), 1);
        if (rlog.size() == 1) chk("t4_readback", rlog[0].d, 16'h5503);

        // T5: m0 locks, withdraws after 2 beats; m1 waiting gets the port after one idle cycle.
        clear_logs();
        @(negedge clk);
        q0.push_back('{1'b0, 1'b1, 16'h0060, 16'h0});
        q0.push_back('{1'b0, 1'b1, 16'h0061, 16'h0});
        @(negedge clk);
        q1.push_back('{1'b0, 1'b0, 16'h0070, 16'h0});
        wait_idle();
        chk("t5_ngnt", glog.size(), 3);
        if (glog.size() == 3) begin
            chk("t5_m_a", glog[0].m, 0);
            chk("t5_m_b", glog[1].m, 0);
            chk("t5_m_c", glog[2].m, 1);
            chk("t5_cyc_b", glog[1].cyc - glog[0].cyc, 1);
            chk("t5_cyc_c", glog[2].cyc - glog[0].cyc, 3);
        end

        // T6: reset the cycle after an m1 read grant.
        clear_logs();
        @(negedge clk);
        q1.push_back('{1'b0, 1'b0, 16'h0080, 16'h0});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m1_gnt && n < 20);
        chk("t6_g1_seen", m1_gnt, 1);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("t6_addr_rst", mem_addr, 16'h0000);
        chk("t6_we_rst", mem_we, 0);
        repeat (3) @(negedge clk);
        chk("t6_no_rv", rlog.size(), 0);
        clear_logs();
        @(negedge clk);
        q0.push_back('{1'b0, 1'b0, 16'h0090, 16'h0});
        q1.push_back('{1'b0, 1'b0, 16'h0091, 16'h0});
        wait_idle();
        chk("t6_ngnt", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("t6_first_m0", glog[0].m, 0);
            chk("t6_second_m1", glog[1].m, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
